// File: rtl/clock_ratio_detector.sv
// Measures the period and high time of a divided clock sampled as data in the clk domain,
// declares lock once the period repeats LOCK_CNT times, and flags a stalled input.
module clock_ratio_detector #(
  parameter int MAX_N    = 255,
  parameter int LOCK_CNT = 3,
  parameter bit SYNC_EN  = 1'b1,
  localparam int W       = $clog2(MAX_N + 2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_cycles,
  output logic         meas_valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] CNT_MAX  = W'(MAX_N + 1);
  localparam logic [W-1:0] CNT_WARN = W'(MAX_N);
  localparam logic [3:0]   LOCK_N   = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    TRACK,
    LOCKED
  } state_t;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic         s_in;
  logic         s_q;
  logic         s_dly_q;
  logic         rise;
  logic         fall;
  logic         to_hit;

  state_t       state_q,  state_d;
  logic [W-1:0] cnt_q,    cnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q,   high_d;
  logic         mv_q,     mv_d;
  logic         locked_q, locked_d;
  logic         to_q,     to_d;
  logic [3:0]   streak_q, streak_d;
  logic         seen_q,   seen_d;

  // Input stage: optional extra synchronizer flop ahead of the sample register
  generate
    if (SYNC_EN) begin : g_sync
      logic sync_q;
      always_ff @(posedge clk) begin
        if (rst) sync_q <= 1'b0;
        else     sync_q <= div_in;
      end
      assign s_in = sync_q;
    end else begin : g_nosync
      assign s_in = div_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= s_in;
      s_dly_q <= s_q;
    end
  end

  // Edge detect and cycle counter
  assign rise   = s_q & ~s_dly_q;
  assign fall   = ~s_q & s_dly_q;
  // A rise on the saturating cycle wins over the timeout
  assign to_hit = (state_q != SEARCH) && !rise && (cnt_q == CNT_WARN);

  always_comb begin
    cnt_d = rise ? W'(1) : sat_inc(cnt_q);
  end

  // Measurement and lock FSM
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    locked_d = locked_q;
    to_d     = 1'b0;
    streak_d = streak_q;
    seen_d   = seen_q | rise;

    if (fall && seen_q) high_d = cnt_q;

    case (state_q)
      SEARCH: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          mv_d     = 1'b1;
          streak_d = 4'd1;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (rise) begin
          period_d = cnt_q;
          mv_d     = 1'b1;
          if (cnt_q == period_q) begin
            if (streak_q + 4'd1 >= LOCK_N) begin
              streak_d = LOCK_N;
              locked_d = 1'b1;
              state_d  = LOCKED;
            end else begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            streak_d = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = cnt_q;
          mv_d     = 1'b1;
          if (cnt_q != period_q) begin
            locked_d = 1'b0;
            streak_d = 4'd1;
            state_d  = TRACK;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (to_hit) begin
      to_d     = 1'b1;
      locked_d = 1'b0;
      state_d  = SEARCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
      streak_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      to_q     <= to_d;
      streak_q <= streak_d;
      seen_q   <= seen_d;
    end
  end

  assign period      = period_q;
  assign high_cycles = high_q;
  assign meas_valid  = mv_q;
  assign locked      = locked_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Scoreboard bench: two detectors (MAX_N=255 synchronized, MAX_N=15 unsynchronized) share one
// divided-clock stimulus; a period-level model predicts each capture and each timeout.
module tb_clock_ratio_detector;

  localparam int MAXN_A = 255;
  localparam int MAXN_B = 15;
  localparam int LC     = 3;
  localparam int WA     = $clog2(MAXN_A + 2);
  localparam int WB     = $clog2(MAXN_B + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          div;
  logic [WA-1:0] period_a, high_a;
  logic          mv_a, locked_a, to_a;
  logic [WB-1:0] period_b, high_b;
  logic          mv_b, locked_b, to_b;

  clock_ratio_detector #(.MAX_N(MAXN_A), .LOCK_CNT(LC), .SYNC_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .div_in(div), .period(period_a), .high_cycles(high_a),
    .meas_valid(mv_a), .locked(locked_a), .timeout(to_a));

  clock_ratio_detector #(.MAX_N(MAXN_B), .LOCK_CNT(LC), .SYNC_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .div_in(div), .period(period_b), .high_cycles(high_b),
    .meas_valid(mv_b), .locked(locked_b), .timeout(to_b));

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    int l;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        ea, eb;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned last_mv_b = 0;
  int          to_cnt_a = 0;
  int          to_cnt_b = 0;

  // Period-level reference model, one slot per detector
  int maxn[2] = '{MAXN_A, MAXN_B};
  int have_prev[2], first_cap[2], last_p[2], streak[2], lockm[2], prev_p[2], prev_h[2], exp_to[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      have_prev[i] = 0; first_cap[i] = 0; last_p[i] = 0; streak[i] = 0;
      lockm[i] = 0; prev_p[i] = 0; prev_h[i] = 0;
    end
  endtask

  task automatic model_rise(input int i, input int h, input int l);
    exp_t e;
    if (have_prev[i] == 0) begin
      have_prev[i] = 1;
      first_cap[i] = 1;
    end else if (prev_p[i] > maxn[i]) begin
      exp_to[i]++;
      lockm[i]     = 0;
      first_cap[i] = 1;
    end else begin
      if (first_cap[i] != 0) begin
        streak[i]    = 1;
        first_cap[i] = 0;
      end else if (prev_p[i] == last_p[i]) begin
        streak[i]++;
        if (streak[i] >= LC) lockm[i] = 1;
      end else begin
        streak[i] = 1;
        lockm[i]  = 0;
      end
      last_p[i] = prev_p[i];
      e.p = prev_p[i];
      e.h = prev_h[i];
      e.l = lockm[i];
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    prev_p[i] = h + l;
    prev_h[i] = h;
  endtask

  task automatic drive_seg(input int h, input int l);
    model_rise(0, h, l);
    model_rise(1, h, l);
    for (int k = 0; k < h; k++) begin
      div = 1'b1;
      @(posedge clk); #1;
    end
    for (int k = 0; k < l; k++) begin
      div = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_a_period"}, int'(period_a), 0);
    check({pfx, "_a_high"},   int'(high_a),   0);
    check({pfx, "_a_mv"},     int'(mv_a),     0);
    check({pfx, "_a_locked"}, int'(locked_a), 0);
    check({pfx, "_a_timeout"},int'(to_a),     0);
    check({pfx, "_b_period"}, int'(period_b), 0);
    check({pfx, "_b_high"},   int'(high_b),   0);
    check({pfx, "_b_mv"},     int'(mv_b),     0);
    check({pfx, "_b_locked"}, int'(locked_b), 0);
    check({pfx, "_b_timeout"},int'(to_b),     0);
  endtask

  task automatic pulse_reset();
    check("a_locked_before_rst", int'(locked_a), lockm[0]);
    check("b_locked_before_rst", int'(locked_b), lockm[1]);
    rst = 1'b1;
    div = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    check("a_queue_at_rst", q_a.size(), 0);
    check("b_queue_at_rst", q_b.size(), 0);
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mv_a) begin
        if (q_a.size() == 0) check("a_mv_unexpected", 1, 0);
        else begin
          ea = q_a.pop_front();
          check("a_period", int'(period_a), ea.p);
          check("a_high",   int'(high_a),   ea.h);
          check("a_locked", int'(locked_a), ea.l);
        end
      end
      if (to_a) to_cnt_a++;
      if (mv_b) begin
        last_mv_b = cyc;
        if (q_b.size() == 0) check("b_mv_unexpected", 1, 0);
        else begin
          eb = q_b.pop_front();
          check("b_period", int'(period_b), eb.p);
          check("b_high",   int'(high_b),   eb.h);
          check("b_locked", int'(locked_b), eb.l);
        end
      end
      if (to_b) begin
        to_cnt_b++;
        check("b_timeout_delay",  int'(cyc - last_mv_b), MAXN_B);
        check("b_timeout_locked", int'(locked_b), 0);
        check("b_timeout_period", int'(period_b), last_p[1]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    exp_to[0] = 0;
    exp_to[1] = 0;
    model_reset();
    rst = 1'b1;
    div = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    repeat (6) drive_seg(2, 2);   // /4 square wave, lock on 4th rise
    repeat (5) drive_seg(3, 2);   // /5, 3 high
    repeat (5) drive_seg(2, 3);   // /5, 2 high
    repeat (6) drive_seg(2, 2);   // back to /4
    repeat (5) drive_seg(3, 3);   // switch to /6 while locked
    repeat (5) drive_seg(2, 2);
    drive_seg(2, 40);             // stall long enough to time out the MAX_N=15 unit
    repeat (6) drive_seg(2, 2);
    repeat (5) drive_seg(4, 4);   // /8, then reset while locked
    pulse_reset();
    repeat (6) drive_seg(4, 4);
    repeat (5) drive_seg(5, 5);   // /10 with a one-cycle glitch in the low phase
    drive_seg(5, 2);
    drive_seg(1, 2);
    repeat (5) drive_seg(5, 5);
    drive_seg(2, 6);
    repeat (8) begin
      @(posedge clk); #1;
    end

    check("a_queue_empty",  q_a.size(), 0);
    check("b_queue_empty",  q_b.size(), 0);
    check("a_timeouts",     to_cnt_a, exp_to[0]);
    check("b_timeouts",     to_cnt_b, exp_to[1]);
    check("b_timeout_once", to_cnt_b, 1);
    check("a_final_locked", int'(locked_a), 1);
    check("b_final_locked", int'(locked_b), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
